wb_gpio_irq: RTL and testbench

WB_GPIO_IRQ -- requirements
Module: wb_gpio_irq

---
 rtl/wb_gpio_pkg.sv | 27 ++
 rtl/gpio_sync.sv | 28 ++
 rtl/wb_gpio_irq.sv | 150 +++++++++++++++
 tb/tb_wb_gpio_irq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/wb_gpio_pkg.sv
// Shared register offsets, arm FSM encoding and byte-select helper for wb_gpio_irq.
package wb_gpio_pkg;

    localparam logic [2:0] REG_DATA_IN    = 3'd0;
    localparam logic [2:0] REG_DATA_OUT   = 3'd1;
    localparam logic [2:0] REG_DIR        = 3'd2;
    localparam logic [2:0] REG_IRQ_EN     = 3'd3;
    localparam logic [2:0] REG_RISE_EN    = 3'd4;
    localparam logic [2:0] REG_FALL_EN    = 3'd5;
    localparam logic [2:0] REG_IRQ_STATUS = 3'd6;
    localparam logic [2:0] REG_RSVD       = 3'd7;

    typedef enum logic {
        WARMUP = 1'b0,
        ARMED  = 1'b1
    } arm_state_e;

    // Expand a 4-bit Wishbone byte select into a 32-bit bit mask.
    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage synchroniser bringing asynchronous pad inputs into the wb_clk domain.
module gpio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

    // Shift the pad sample one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    end

    // Synchroniser flops, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone classic GPIO block with per-pin direction, edge-triggered interrupts
// and a warm-up window that hides edges created by the synchroniser filling.
module wb_gpio_irq
    import wb_gpio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic [2:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq_o
);

    localparam logic [1:0] WARM_LAST = 2'(SYNC_STAGES);

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out_q, data_out_d, dir_q, dir_d;
    logic [WIDTH-1:0] irq_en_q, irq_en_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d, prev_q, prev_d;
    logic [31:0]      dat_q, dat_d, mask32;
    logic             ack_q, ack_d, irq_q, irq_d;
    arm_state_e       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0] wmask, wdat, clr, evt, rd;
    logic             access, wr;

    gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (wb_clk),
        .rst (wb_rst),
        .d_i (gpio_i),
        .q_o (data_in)
    );

    // Warm-up FSM: hold off edge events until synchroniser and prev hold real pin state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WARMUP: begin
                if (cnt_q == WARM_LAST) state_d = ARMED;
                else                    cnt_d   = cnt_q + 2'd1;
            end
            ARMED:   state_d = ARMED;
            default: state_d = WARMUP;
        endcase
    end

    // Bus decode, register writes, read mux and interrupt status next-state.
    always_comb begin
        mask32     = sel_to_mask(wb_sel_i);
        wmask      = mask32[WIDTH-1:0];
        wdat       = wb_dat_i[WIDTH-1:0];
        access     = wb_cyc_i & wb_stb_i & ~ack_q;
        wr         = access & wb_we_i;
        ack_d      = access;
        dat_d      = dat_q;
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        clr        = '0;
        rd         = '0;

        if (wr) begin
            case (wb_adr_i)
                REG_DATA_OUT:   data_out_d = (data_out_q & ~wmask) | (wdat & wmask);
                REG_DIR:        dir_d      = (dir_q      & ~wmask) | (wdat & wmask);
                REG_IRQ_EN:     irq_en_d   = (irq_en_q   & ~wmask) | (wdat & wmask);
                REG_RISE_EN:    rise_en_d  = (rise_en_q  & ~wmask) | (wdat & wmask);
                REG_FALL_EN:    fall_en_d  = (fall_en_q  & ~wmask) | (wdat & wmask);
                REG_IRQ_STATUS: clr        = wdat & wmask;
                default:        ;
            endcase
        end

        case (wb_adr_i)
            REG_DATA_IN:    rd = data_in;
            REG_DATA_OUT:   rd = data_out_q;
            REG_DIR:        rd = dir_q;
            REG_IRQ_EN:     rd = irq_en_q;
            REG_RISE_EN:    rd = rise_en_q;
            REG_FALL_EN:    rd = fall_en_q;
            REG_IRQ_STATUS: rd = status_q;
            default:        rd = '0;
        endcase
        if (access) begin
            dat_d = '0;
            if (!wb_we_i) dat_d[WIDTH-1:0] = rd;
        end

        // A new edge event overrides a simultaneous W1C on the same bit.
        evt      = (state_q == ARMED) ?
                   ((data_in & ~prev_q & rise_en_q) | (~data_in & prev_q & fall_en_q)) : '0;
        status_d = (status_q & ~clr) | evt;
        prev_d   = data_in;
        irq_d    = |(status_q & irq_en_q);
    end

    // State registers; reset also aborts any in-flight access.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            data_out_q <= OUT_RESET;
            dir_q      <= '0;
            irq_en_q   <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            prev_q     <= '0;
            dat_q      <= '0;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
            state_q    <= WARMUP;
            cnt_q      <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            prev_q     <= prev_d;
            dat_q      <= dat_d;
            ack_q      <= ack_d;
            irq_q      <= irq_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign gpio_o   = data_out_q;
    assign gpio_oe  = dir_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Directed bench for wb_gpio_irq: an 8-bit instance and a 32-bit instance share the bus.
module tb_wb_gpio_irq;
    import wb_gpio_pkg::*;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic [2:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i;
    logic [7:0]  gpio_i;

    logic [31:0] dat8, dat32;
    logic        ack8, ack32, irq8, irq32;
    logic [7:0]  gpio_o8, gpio_oe8;
    logic [31:0] gpio_o32, gpio_oe32;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] rdat;

    wb_gpio_irq #(.WIDTH(8), .SYNC_STAGES(2), .OUT_RESET(8'h00)) u_dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(dat8), .wb_ack_o(ack8), .gpio_i(gpio_i), .gpio_o(gpio_o8),
        .gpio_oe(gpio_oe8), .irq_o(irq8)
    );

    wb_gpio_irq #(.WIDTH(32), .SYNC_STAGES(2), .OUT_RESET(32'hCAFE_0001)) u_dut32 (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(dat32), .wb_ack_o(ack32), .gpio_i({24'h0, gpio_i}), .gpio_o(gpio_o32),
        .gpio_oe(gpio_oe32), .irq_o(irq32)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge wb_clk);
        #1;
    endtask

    // All bus tasks start #1 after a rising edge; ack must appear on the very next edge.
    task automatic wb_wr(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        tick(1);
        chk("wr_ack", {30'd0, ack32, ack8}, 32'd3);
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick(1);
        chk("wr_ack_drop", {30'd0, ack32, ack8}, 32'd0);
    endtask

    task automatic wb_rd(input logic [2:0] adr, output logic [31:0] d8, output logic [31:0] d32);
        wb_adr_i = adr; wb_dat_i = 32'h0; wb_sel_i = 4'hF;
        wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        tick(1);
        chk("rd_ack", {30'd0, ack32, ack8}, 32'd3);
        d8 = dat8; d32 = dat32;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [31:0] r32;
        wb_rst = 1'b1; gpio_i = 8'hFF;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick(3);
        chk("rst_ack", {31'd0, ack8}, 32'd0);
        chk("rst_dat", dat8, 32'd0);
        chk("rst_irq", {31'd0, irq8}, 32'd0);
        chk("rst_gpio_o", {24'd0, gpio_o8}, 32'h00);
        chk("rst_gpio_oe", {24'd0, gpio_oe8}, 32'h00);
        chk("rst_gpio_o32", gpio_o32, 32'hCAFE_0001);

        // Pins held high through reset: arm rise detection at once, expect no spurious event.
        wb_rst = 1'b0;
        wb_wr(REG_RISE_EN, 32'hFF, 4'hF);
        wb_wr(REG_IRQ_EN, 32'hFF, 4'hF);
        tick(2);
        wb_rd(REG_DATA_IN, rdat, r32);
        chk("warm_data_in", rdat, 32'hFF);
        wb_rd(REG_IRQ_STATUS, rdat, r32);
        chk("warm_status", rdat, 32'h00);
        chk("warm_irq", {31'd0, irq8}, 32'd0);
        wb_wr(REG_RISE_EN, 32'h0, 4'hF);
        wb_wr(REG_IRQ_EN, 32'h0, 4'hF);

        // Direction and output drive.
        wb_wr(REG_DIR, 32'h0F, 4'hF);
        wb_wr(REG_DATA_OUT, 32'hA5, 4'hF);
        chk("gpio_oe", {24'd0, gpio_oe8}, 32'h0F);
        chk("gpio_o", {24'd0, gpio_o8}, 32'hA5);
        chk("gpio_o32", gpio_o32, 32'h0000_00A5);
        wb_rd(REG_DIR, rdat, r32);
        chk("rd_dir", rdat, 32'h0F);

        // Byte selects and width truncation.
        wb_wr(REG_DATA_OUT, 32'hFFFF_FFFF, 4'b0001);
        chk("sel_w8", {24'd0, gpio_o8}, 32'hFF);
        chk("sel_w32", gpio_o32, 32'h0000_00FF);
        wb_wr(REG_DATA_OUT, 32'h1234_5678, 4'b1010);
        chk("sel_hi_w8", {24'd0, gpio_o8}, 32'hFF);
        chk("sel_hi_w32", gpio_o32, 32'h1200_56FF);
        wb_rd(REG_DATA_OUT, rdat, r32);
        chk("rd_dout8", rdat, 32'hFF);
        chk("rd_dout32", r32, 32'h1200_56FF);
        wb_rd(REG_RSVD, rdat, r32);
        chk("rd_rsvd", rdat, 32'h0);
        chk("rd_rsvd32", r32, 32'h0);

        // Rising edge on pin 0 (an output pin) -> status at sync+1, irq one cycle later.
        gpio_i = 8'h00;
        tick(4);
        wb_wr(REG_RISE_EN, 32'h01, 4'hF);
        wb_wr(REG_IRQ_EN, 32'h01, 4'hF);
        gpio_i = 8'h01;
        tick(3);
        chk("rise_irq_early", {31'd0, irq8}, 32'd0);
        tick(1);
        chk("rise_irq", {31'd0, irq8}, 32'd1);
        wb_rd(REG_IRQ_STATUS, rdat, r32);
        chk("rise_status", rdat, 32'h01);
        wb_wr(REG_IRQ_STATUS, 32'h01, 4'hF);
        chk("w1c_irq", {31'd0, irq8}, 32'd0);
        wb_rd(REG_IRQ_STATUS, rdat, r32);
        chk("w1c_status", rdat, 32'h00);

        // Falling edge on pin 1; then a W1C landing with a second fall must leave the bit set.
        wb_wr(REG_FALL_EN, 32'h02, 4'hF);
        gpio_i = 8'h03;
        tick(4);
        gpio_i = 8'h01;
        tick(4);
        wb_rd(REG_IRQ_STATUS, rdat, r32);
        chk("fall_status", rdat, 32'h02);
        gpio_i = 8'h03;
        tick(4);
        gpio_i = 8'h01;
        tick(2);
        wb_wr(REG_IRQ_STATUS, 32'h02, 4'hF);
        wb_rd(REG_IRQ_STATUS, rdat, r32);
        chk("set_wins", rdat, 32'h02);
        wb_wr(REG_IRQ_STATUS, 32'h02, 4'hF);
        wb_rd(REG_IRQ_STATUS, rdat, r32);
        chk("clr_only", rdat, 32'h00);

        // Reset arriving with a pending write aborts it.
        wb_wr(REG_DATA_OUT, 32'h5A, 4'hF);
        chk("pre_abort", {24'd0, gpio_o8}, 32'h5A);
        wb_adr_i = REG_DATA_OUT; wb_dat_i = 32'h33; wb_sel_i = 4'hF;
        wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        #1 wb_rst = 1'b1;
        tick(1);
        chk("abort_ack", {30'd0, ack32, ack8}, 32'd0);
        chk("abort_dout", {24'd0, gpio_o8}, 32'h00);
        chk("abort_dout32", gpio_o32, 32'hCAFE_0001);
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        wb_rst = 1'b0;
        tick(1);
        chk("abort_ack_after", {30'd0, ack32, ack8}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
